// File: rtl/fir_63_tap_pkg.sv
// Shared constants, types, coefficient table and round/saturate helper for
// the 63-tap low-pass FIR.
//   DATA_W : signed sample width (input and output)
//   COEF_W : signed coefficient width, Q1.15 (32768 = 1.0)
//   NTAPS  : tap count (odd, linear phase)
//   ACC_W  : accumulator width, wide enough that the tap sum cannot overflow
package fir_63_tap_pkg;

   localparam int DATA_W   = 10;
   localparam int COEF_W   = 16;
   localparam int NTAPS    = 63;
   localparam int ACC_W    = 32;
   localparam int HALF     = NTAPS / 2;   // index of the centre tap
   localparam int FRAC_W   = COEF_W - 1;  // Q1.15 fraction bits

   localparam int SAMPLE_MAX = 2**(DATA_W-1) - 1;
   localparam int SAMPLE_MIN = -(2**(DATA_W-1));

   typedef logic signed [DATA_W-1:0]      sample_t;
   typedef logic signed [COEF_W-1:0]      coef_t;
   typedef logic signed [ACC_W-1:0]       acc_t;
   typedef logic signed [DATA_W:0]        pre_t;   // symmetric pre-add result
   typedef logic signed [DATA_W+COEF_W:0] prod_t;  // pre-add times coefficient

   // Hamming-windowed sinc, cutoff 0.1*fs, normalised to sum 32768 with the
   // residual folded into the centre tap so DC gain is exactly one.
   localparam coef_t H [0:NTAPS-1] = '{
       16'sd16,     16'sd0,   -16'sd19,   -16'sd36,   -16'sd43,   -16'sd33,
       16'sd0,      16'sd49,   16'sd96,    16'sd117,   16'sd87,    16'sd0,
      -16'sd123,   -16'sd234, -16'sd275,  -16'sd198,   16'sd0,     16'sd267,
       16'sd501,    16'sd579,  16'sd414,   16'sd0,    -16'sd560,  -16'sd1064,
      -16'sd1261,  -16'sd939,  16'sd0,     16'sd1477,  16'sd3241,  16'sd4920,
       16'sd6124,   16'sd6562, 16'sd6124,  16'sd4920,  16'sd3241,  16'sd1477,
       16'sd0,     -16'sd939, -16'sd1261, -16'sd1064, -16'sd560,   16'sd0,
       16'sd414,    16'sd579,  16'sd501,   16'sd267,   16'sd0,    -16'sd198,
      -16'sd275,   -16'sd234, -16'sd123,   16'sd0,     16'sd87,    16'sd117,
       16'sd96,     16'sd49,   16'sd0,    -16'sd33,   -16'sd43,   -16'sd36,
      -16'sd19,     16'sd0,    16'sd16
   };

   // Round half-up out of Q1.15, then clamp to the sample range.
   function automatic sample_t sat_round(input acc_t acc);
      acc_t r;
      r = (acc + acc_t'(2**(FRAC_W-1))) >>> FRAC_W;
      if (r > acc_t'(SAMPLE_MAX))
         sat_round = sample_t'(SAMPLE_MAX);
      else if (r < acc_t'(SAMPLE_MIN))
         sat_round = sample_t'(SAMPLE_MIN);
      else
         sat_round = r[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up and saturate from the accumulator width down to
// the sample width.
//   acc : signed accumulated tap sum (Q1.15 scaled)
//   y   : signed rounded, saturated sample
module fir_round_sat
   import fir_63_tap_pkg::*;
(
   input  logic signed [ACC_W-1:0]  acc,
   output logic signed [DATA_W-1:0] y
);

   always_comb begin
      y = sat_round(acc);
   end

endmodule

// File: rtl/fir_63_tap.sv
// 63-tap direct-form low-pass FIR, one sample in and one result out per clk.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, flushes delay line and output
//   x_in : signed input sample, taken every edge
//   y    : signed filtered output, registered (1 clk latency)
module fir_63_tap
   import fir_63_tap_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [DATA_W-1:0] x_in,
   output logic signed [DATA_W-1:0] y
);

   sample_t tap     [NTAPS];
   sample_t tap_nxt [NTAPS];
   acc_t    acc;
   pre_t    pre;
   prod_t   prod;
   sample_t y_nxt;

   // The sum is taken over the delay line as it will be after this edge, so
   // the sample arriving now already contributes to the registered output.
   always_comb begin
      tap_nxt[0] = x_in;
      for (int unsigned k = 1; k < NTAPS; k++) begin
         tap_nxt[k] = tap[k-1];
      end
   end

   // Symmetric taps share a multiplier; the pre-add is one bit wider so the
   // folded form stays bit-identical to the direct form.
   always_comb begin
      acc  = '0;
      pre  = '0;
      prod = '0;
      for (int unsigned k = 0; k < HALF; k++) begin
         pre  = pre_t'(tap_nxt[k]) + pre_t'(tap_nxt[NTAPS-1-k]);
         prod = prod_t'(pre) * prod_t'(H[k]);
         acc  = acc + acc_t'(prod);
      end
      prod = prod_t'(tap_nxt[HALF]) * prod_t'(H[HALF]);
      acc  = acc + acc_t'(prod);
   end

   fir_round_sat u_round_sat (
      .acc (acc),
      .y   (y_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < NTAPS; k++) begin
            tap[k] <= '0;
         end
         y <= '0;
      end else begin
         for (int unsigned k = 0; k < NTAPS; k++) begin
            tap[k] <= tap_nxt[k];
         end
         y <= y_nxt;
      end
   end

endmodule

// File: tb/tb_fir_63_tap.sv
module tb_fir_63_tap;
   import fir_63_tap_pkg::*;

   logic                     clk = 1'b0;
   logic                     rst;
   logic signed [DATA_W-1:0] x_in;
   logic signed [DATA_W-1:0] y;

   int tests  = 0;
   int failed = 0;

   // Reference history: hist[k] is x(n-k), most recent sample first.
   int hist[$];

   int tone [20] = '{0, 498, 150, -406, -243, 255, 243, -105, -300, 120,
                     0, -120, 300, 105, -243, -255, 243, 406, -150, -498};

   fir_63_tap dut (
      .clk  (clk),
      .rst  (rst),
      .x_in (x_in),
      .y    (y)
   );

   always #5 clk = ~clk;

   // Convolution with the coefficient table in 64-bit integers, then
   // floor((sum + 2^14) / 2^15) and clamp to the 10-bit range.
   function automatic int ref_out();
      longint sum;
      sum = 0;
      for (int k = 0; k < NTAPS; k++) begin
         sum += longint'(H[k]) * longint'(hist[k]);
      end
      sum = (sum + 64'sd16384) >>> 15;
      if (sum > 511)  sum = 511;
      if (sum < -512) sum = -512;
      return int'(sum);
   endfunction

   function automatic void flush_model();
      hist.delete();
      for (int k = 0; k < NTAPS; k++) hist.push_back(0);
   endfunction

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one sample away from the edge, sample y just after the edge.
   task automatic step(input logic r, input int x, input string tag);
      int exp;
      @(negedge clk);
      rst  = r;
      x_in = DATA_W'(x);
      @(posedge clk);
      #1;
      if (r) begin
         flush_model();
         exp = 0;
      end else begin
         hist.push_front(x);
         void'(hist.pop_back());
         exp = ref_out();
      end
      check(tag, y, exp);
   endtask

   initial begin
      int s;
      int x;
      logic r;

      flush_model();
      rst  = 1'b1;
      x_in = '0;

      // Reset held for three edges, then zeros keep the output at zero.
      for (int i = 0; i < 3; i++) step(1'b1, 0, "reset");
      for (int i = 0; i < 5; i++) step(1'b0, 0, "zero_after_release");

      // Impulse response: 511*h[k] rounded, then back to zero.
      step(1'b0, 511, "impulse");
      for (int i = 1; i < NTAPS + 2; i++) step(1'b0, 0, "impulse");
      check("impulse_tail_zero", y, 0);

      // DC steps at both rails must reproduce the input exactly.
      for (int i = 0; i < NTAPS + 5; i++) step(1'b0, 511, "dc_pos");
      check("dc_pos_final", y, 511);
      for (int i = 0; i < NTAPS + 5; i++) step(1'b0, -512, "dc_neg");
      check("dc_neg_final", y, -512);

      // Worst-case patterns aligned with coefficient signs: must clamp.
      for (int k = NTAPS - 1; k >= 0; k--) begin
         s = (H[k] > 0) ? 511 : ((H[k] < 0) ? -511 : 0);
         step(1'b0, s, "sat_pos_fill");
      end
      check("sat_pos_clamp", y, 511);
      for (int k = NTAPS - 1; k >= 0; k--) begin
         s = (H[k] > 0) ? -511 : ((H[k] < 0) ? 511 : 0);
         step(1'b0, s, "sat_neg_fill");
      end
      check("sat_neg_clamp", y, -512);

      // Tone with a one-edge reset at sample 100.
      step(1'b1, 0, "pre_tone_reset");
      for (int i = 0; i < 256; i++) begin
         if (i == 100) begin
            step(1'b1, tone[i % 20], "mid_reset");
            check("mid_reset_zero", y, 0);
         end else begin
            step(1'b0, tone[i % 20], "tone_after_reset");
         end
      end

      // Uninterrupted tone against the reference.
      step(1'b1, 0, "pre_golden_reset");
      for (int i = 0; i < 256; i++) step(1'b0, tone[i % 20], "golden");

      // Random samples with occasional resets, biased toward the rails.
      for (int i = 0; i < 300; i++) begin
         r = ($urandom_range(0, 39) == 0);
         case ($urandom_range(0, 7))
            0:       x = 511;
            1:       x = -512;
            default: x = int'($urandom_range(0, 1023)) - 512;
         endcase
         step(r, x, "random");
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
